// File: rtl/ply_tone_player_pkg.sv
// Shared definitions for the PLY tone player.
// Holds the command field layout, the playback FSM state encoding and
// small helpers that split a 16-bit note command into its fields.
package ply_tone_player_pkg;

  localparam int CMD_W         = 16;
  localparam int CMD_BEATS_MSB = 15;
  localparam int CMD_BEATS_LSB = 12;
  localparam int CMD_HALF_MSB  = 11;
  localparam int CMD_HALF_LSB  = 0;

  localparam int BEATS_W = CMD_BEATS_MSB - CMD_BEATS_LSB + 1;
  localparam int HALF_W  = CMD_HALF_MSB - CMD_HALF_LSB + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  function automatic logic [BEATS_W-1:0] cmd_beats(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_BEATS_MSB:CMD_BEATS_LSB];
  endfunction

  function automatic logic [HALF_W-1:0] cmd_half(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_HALF_MSB:CMD_HALF_LSB];
  endfunction

endpackage

// File: rtl/ply_tone_player_cmd_fifo.sv
// Synchronous command FIFO with flush.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       empties the FIFO at the next edge (beats push and pop)
//   push        write push_data when not full
//   pop         discard the head entry when not empty
//   head        current head entry (valid while empty is low)
//   count       number of entries held
//   full/empty  occupancy flags
module ply_tone_player_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count/empty guard every
  // read, so resetting it would only add a reset net to each storage bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ply_tone_player.sv
// PLY command responder: buffers note commands and plays each one as a
// square wave for a programmed number of beats.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       abort: empty the FIFO and stop the current note
//   cmd_valid   CPU presents a note command on cmd_data
//   cmd_data    [15:12] beats, [11:0] half-period in tone ticks
//   cmd_ready   FIFO can accept a command this cycle
//   audio_out   square-wave output
//   busy        note playing or commands queued
//   fifo_count  entries held in the FIFO
//   note_done   one-cycle pulse when a note completes normally
module ply_tone_player
  import ply_tone_player_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int PRESCALE   = 50,
  parameter  int BEAT_TICKS = 12500,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             audio_out,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             note_done
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  state_e             state;
  state_e             next_state;
  logic [CMD_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               note_end;
  logic               tick;
  logic               beat_end;
  logic               tone_flip;
  logic [PS_W-1:0]    prescaler;
  logic [BT_W-1:0]    beat_cnt;
  logic [HALF_W-1:0]  tone_cnt;
  logic [HALF_W-1:0]  half_period;
  logic [BEATS_W-1:0] beats_left;

  assign cmd_ready = ~full & ~flush;
  assign busy      = (state == ST_PLAY) | (fifo_count != '0);

  ply_tone_player_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(CMD_W)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (cmd_valid & cmd_ready),
    .push_data(cmd_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
  );

  assign tick      = (prescaler == PS_W'(PRESCALE - 1));
  assign beat_end  = (beat_cnt == BT_W'(BEAT_TICKS - 1));
  assign tone_flip = (half_period != '0) && (tone_cnt == half_period - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    note_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // Zero-beat commands are consumed without playing.
          if (cmd_beats(head) != '0) next_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick && beat_end && beats_left == BEATS_W'(1)) begin
          note_end   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Flush outranks everything, including a pop or a completing note.
    if (flush) begin
      next_state = ST_IDLE;
      pop        = 1'b0;
      note_end   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      beat_cnt    <= '0;
      tone_cnt    <= '0;
      half_period <= '0;
      beats_left  <= '0;
      audio_out   <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      note_done <= note_end;
      if (flush) begin
        prescaler   <= '0;
        beat_cnt    <= '0;
        tone_cnt    <= '0;
        half_period <= '0;
        beats_left  <= '0;
        audio_out   <= 1'b0;
      end else if (state == ST_IDLE) begin
        audio_out <= 1'b0;
        if (pop && cmd_beats(head) != '0) begin
          half_period <= cmd_half(head);
          beats_left  <= cmd_beats(head);
          prescaler   <= '0;
          beat_cnt    <= '0;
          tone_cnt    <= '0;
        end
      end else begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          if (tone_flip) begin
            audio_out <= ~audio_out;
            tone_cnt  <= '0;
          end else begin
            tone_cnt <= tone_cnt + 1'b1;
          end
          if (beat_end) begin
            beat_cnt <= '0;
            if (beats_left == BEATS_W'(1)) audio_out <= 1'b0;
            else                           beats_left <= beats_left - 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ply_tone_player.sv
// Self-checking bench for ply_tone_player (PRESCALE=2, BEAT_TICKS=4,
// FIFO_DEPTH=4). A note-level reference model tracks the queue and the time
// elapsed in the current note, and derives the waveform from that time.
module tb_ply_tone_player;

  localparam int DEPTH = 4;
  localparam int PS    = 2;
  localparam int BT    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          cmd_valid;
  logic [15:0]   cmd_data;
  logic          cmd_ready;
  logic          audio_out;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          note_done;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [15:0] q[$];
  bit          m_play;
  int          m_k;      // clk cycles spent in the current note so far
  logic [15:0] m_cur;
  bit          m_done;

  ply_tone_player #(
    .FIFO_DEPTH(DEPTH),
    .PRESCALE  (PS),
    .BEAT_TICKS(BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .audio_out (audio_out),
    .busy      (busy),
    .fifo_count(fifo_count),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int note_len(input logic [15:0] c);
    return int'(c[15:12]) * BT * PS;
  endfunction

  // Output level k cycles into a note: ticks elapsed = k/PS, and the level
  // flips after every half_period ticks.
  function automatic bit m_audio();
    int half;
    if (!m_play) return 1'b0;
    half = int'(m_cur[11:0]);
    if (half == 0) return 1'b0;
    return ((m_k / PS) / half) % 2 == 1;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_play = 1'b0;
    m_k    = 0;
    m_cur  = '0;
    m_done = 1'b0;
  endfunction

  // Advance the model by one clk edge with the inputs present before it.
  function automatic void model_step(input bit f, input bit v, input logic [15:0] d);
    bit acc;
    acc    = v && !f && (q.size() < DEPTH);
    m_done = 1'b0;
    if (f) begin
      q.delete();
      m_play = 1'b0;
      m_k    = 0;
    end else begin
      if (m_play) begin
        m_k++;
        if (m_k == note_len(m_cur)) begin
          m_play = 1'b0;
          m_done = 1'b1;
        end
      end else if (q.size() != 0) begin
        logic [15:0] c;
        c = q.pop_front();
        if (c[15:12] != 4'd0) begin
          m_play = 1'b1;
          m_k    = 0;
          m_cur  = c;
        end
      end
      if (acc) q.push_back(d);
    end
  endfunction

  // One clk cycle: drive inputs, check cmd_ready, take the edge, check the
  // registered outputs against the model.
  task automatic cycle(input bit f, input bit v, input logic [15:0] d);
    flush     = f;
    cmd_valid = v;
    cmd_data  = d;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'((q.size() < DEPTH) && !f));
    @(posedge clk);
    model_step(f, v, d);
    #1;
    check("audio_out",  32'(audio_out),  32'(m_audio()));
    check("note_done",  32'(note_done),  32'(m_done));
    check("busy",       32'(busy),       32'(m_play || q.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
  endtask

  // Hold a command on the bus until the FIFO takes it.
  task automatic push_hold(input logic [15:0] d);
    for (int i = 0; i < 200; i++) begin
      bit acc;
      acc = q.size() < DEPTH;
      cycle(1'b0, 1'b1, d);
      if (acc) return;
    end
    check("push_timeout", 32'(cmd_ready), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (!m_play && q.size() == 0) break;
      cycle(1'b0, 1'b0, 16'h0);
    end
    cycle(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    model_reset();
    #3;
    check("rst_audio",  32'(audio_out),  32'(0));
    check("rst_done",   32'(note_done),  32'(0));
    check("rst_ready",  32'(cmd_ready),  32'(1));
    check("rst_busy",   32'(busy),       32'(0));
    check("rst_count",  32'(fifo_count), 32'(0));
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single tone: 2 beats, half-period 3 ticks.
    push_hold(16'h2003);
    drain();

    // Full FIFO: hold under flush with valid up, then six back-to-back pushes.
    cycle(1'b1, 1'b1, 16'h1001);
    cycle(1'b1, 1'b1, 16'h1001);
    push_hold(16'h1001);
    push_hold(16'h1002);
    push_hold(16'h1003);
    push_hold(16'h1004);
    push_hold(16'h1005);
    push_hold(16'h1001);
    drain();

    // Rest, zero-beat, then a fast tone.
    push_hold(16'h1000);
    push_hold(16'h0005);
    push_hold(16'h1001);
    drain();

    // Flush mid-note with two notes queued.
    push_hold(16'h3002);
    push_hold(16'h1003);
    push_hold(16'h1004);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    check("flush_count", 32'(fifo_count), 32'(0));
    check("flush_busy",  32'(busy),       32'(0));
    push_hold(16'h1001);
    drain();

    // Asynchronous reset in the middle of a note.
    push_hold(16'h2002);
    push_hold(16'h1001);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    #1;
    check("arst_audio", 32'(audio_out),  32'(0));
    check("arst_done",  32'(note_done),  32'(0));
    check("arst_ready", 32'(cmd_ready),  32'(1));
    check("arst_busy",  32'(busy),       32'(0));
    check("arst_count", 32'(fifo_count), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0);

    // Simultaneous push and pop: the IDLE pop coincides with the second push.
    push_hold(16'h1002);
    push_hold(16'h1003);
    check("pushpop_count", 32'(fifo_count), 32'(1));
    drain();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 2500; i++) begin
      bit          f;
      bit          v;
      logic [15:0] d;
      f = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = {4'($urandom_range(0, 3)), 12'($urandom_range(0, 5))};
      cycle(f, v, d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
